// File: rtl/bank_isu_issue_select_if.sv
// Issue request channel between the issue selector and the channel request path,
// including the slot acknowledge returned to the issue queue.
interface bank_isu_issue_select_if #(
    parameter int PTR_WIDTH = 8
) ();
    logic                 issue_valid;
    logic [PTR_WIDTH-1:0] issue_ptr;
    logic [1:0]           issue_ch_id;
    logic                 issue_is_read;
    logic                 issue_ready;
    logic                 iq_issue_ack;
    logic [PTR_WIDTH-1:0] iq_issue_ack_ptr;

    modport master (
        output issue_valid, issue_ptr, issue_ch_id, issue_is_read,
        output iq_issue_ack, iq_issue_ack_ptr,
        input  issue_ready
    );

    modport slave (
        input  issue_valid, issue_ptr, issue_ch_id, issue_is_read,
        input  iq_issue_ack, iq_issue_ack_ptr,
        output issue_ready
    );
endinterface

// File: rtl/bank_isu_issue_select.sv
// Oldest-first issue select with a registered valid/ready output stage and
// per-channel outstanding-read tracking that returns credits on read responses.
module bank_isu_issue_select #(
    parameter int CHANNEL_NUM     = 3,
    parameter int PTR_WIDTH       = 8,
    parameter int DEPTH           = 1 << PTR_WIDTH,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DEPTH-1:0]       iq_valid_array,
    input  logic [DEPTH-1:0]       credit_allow_array,
    input  logic [PTR_WIDTH-1:0]   iq_bottom_ptr,
    input  logic [DEPTH-1:0]       iq_op_is_read_array,
    input  logic [2*DEPTH-1:0]     ch_id_array,
    bank_isu_issue_select_if.master issue_if,
    input  logic                   rd_resp_valid,
    input  logic [1:0]             rd_resp_ch_id,
    output logic [CHANNEL_NUM-1:0] channels_credit_release,
    output logic [CHANNEL_NUM-1:0] channels_outstanding_full
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e                         r_state;
    state_e                         w_state_nxt;
    logic [PTR_WIDTH-1:0]           r_ptr;
    logic [1:0]                     r_ch_id;
    logic                           r_is_read;
    logic [DEPTH-1:0]               w_held_mask;
    logic [DEPTH-1:0]               w_eligible;
    logic                           w_sel_found;
    logic [PTR_WIDTH-1:0]           w_sel_ptr;
    logic                           w_load;
    logic                           w_ack;
    logic [CHANNEL_NUM*CNT_W-1:0]   r_outstanding;
    logic [CHANNEL_NUM-1:0]         r_release;
    logic [CHANNEL_NUM-1:0]         w_inc;
    logic [CHANNEL_NUM-1:0]         w_dec;
    logic [CHANNEL_NUM-1:0]         w_resp_hit;

    // The slot sitting in the output stage stays valid in the IQ until its ack edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves a latch.
        w_held_mask = '0;
        if (r_state == ST_FULL) w_held_mask[r_ptr] = 1'b1;
        w_eligible = iq_valid_array & credit_allow_array & ~w_held_mask;
    end

    // Scan from the top of the circle down so the entry closest to the bottom pointer wins.
    always_comb begin
        logic [PTR_WIDTH-1:0] v_idx;
        w_sel_found = 1'b0;
        w_sel_ptr   = '0;
        v_idx       = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            v_idx = iq_bottom_ptr + PTR_WIDTH'(k);
            if (w_eligible[v_idx]) begin
                w_sel_found = 1'b1;
                w_sel_ptr   = v_idx;
            end
        end
    end

    assign w_ack = (r_state == ST_FULL) & issue_if.issue_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_sel_found) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (issue_if.issue_ready) begin
                    w_load      = w_sel_found;
                    w_state_nxt = w_sel_found ? ST_FULL : ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_EMPTY;
            r_ptr     <= '0;
            r_ch_id   <= '0;
            r_is_read <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            r_state <= w_state_nxt;
            if (w_load) begin
                r_ptr     <= w_sel_ptr;
                r_ch_id   <= ch_id_array[{w_sel_ptr, 1'b0} +: 2];
                r_is_read <= iq_op_is_read_array[w_sel_ptr];
            end
        end
    end

    assign issue_if.issue_valid      = (r_state == ST_FULL);
    assign issue_if.issue_ptr        = r_ptr;
    assign issue_if.issue_ch_id      = r_ch_id;
    assign issue_if.issue_is_read    = r_is_read;
    assign issue_if.iq_issue_ack     = w_ack;
    assign issue_if.iq_issue_ack_ptr = r_ptr;

    // A response on an empty channel is an upstream error: it neither underflows nor releases.
    always_comb begin
        w_inc      = '0;
        w_dec      = '0;
        w_resp_hit = '0;
        for (int c = 0; c < CHANNEL_NUM; c++) begin
            w_inc[c]      = w_ack & r_is_read & (r_ch_id == 2'(c));
            w_resp_hit[c] = rd_resp_valid & (rd_resp_ch_id == 2'(c));
            w_dec[c]      = w_resp_hit[c] & (r_outstanding[c*CNT_W +: CNT_W] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the counters are a handful of flops, not a RAM, so they are cleared by reset.
            r_outstanding <= '0;
            r_release     <= '0;
        end else begin
            r_release <= w_dec;
            for (int c = 0; c < CHANNEL_NUM; c++) begin
                if (w_inc[c] && !w_dec[c] && r_outstanding[c*CNT_W +: CNT_W] != CNT_MAX)
                    r_outstanding[c*CNT_W +: CNT_W] <= r_outstanding[c*CNT_W +: CNT_W] + 1'b1;
                else if (w_dec[c] && !w_inc[c])
                    r_outstanding[c*CNT_W +: CNT_W] <= r_outstanding[c*CNT_W +: CNT_W] - 1'b1;
            end
        end
    end

    assign channels_credit_release = r_release;

    for (genvar c = 0; c < CHANNEL_NUM; c++) begin : g_ch
        assign channels_outstanding_full[c] = (r_outstanding[c*CNT_W +: CNT_W] == CNT_MAX);

        a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
            !(w_resp_hit[c] && r_outstanding[c*CNT_W +: CNT_W] == '0));
        a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
            !(w_inc[c] && !w_dec[c] && channels_outstanding_full[c]));
    end

endmodule

// File: tb/tb_bank_isu_issue_select.sv
// Directed bench for bank_isu_issue_select: issue order is checked through a
// scoreboard of expected issues, counters and release pulses against fixed values.
module tb_bank_isu_issue_select;

    localparam int PW = 8;
    localparam int D  = 256;
    localparam int CN = 3;

    typedef struct packed {
        logic [PW-1:0] ptr;
        logic [1:0]    ch;
        logic          rd;
    } issue_t;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b1;
    logic [D-1:0]   iq_valid;
    logic [D-1:0]   credit_allow;
    logic [D-1:0]   is_read;
    logic [2*D-1:0] ch_ids;
    logic [PW-1:0]  bottom;
    logic           rd_resp_valid;
    logic [1:0]     rd_resp_ch;
    logic [CN-1:0]  release_o;
    logic [CN-1:0]  full_o;

    issue_t sb[$];
    int     checks = 0;
    int     errors = 0;

    always #5 clk = ~clk;

    bank_isu_issue_select_if #(.PTR_WIDTH(PW)) u_if ();

    bank_isu_issue_select #(
        .CHANNEL_NUM(CN), .PTR_WIDTH(PW), .DEPTH(D), .MAX_OUTSTANDING(8)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .iq_valid_array           (iq_valid),
        .credit_allow_array       (credit_allow),
        .iq_bottom_ptr            (bottom),
        .iq_op_is_read_array      (is_read),
        .ch_id_array              (ch_ids),
        .issue_if                 (u_if.master),
        .rd_resp_valid            (rd_resp_valid),
        .rd_resp_ch_id            (rd_resp_ch),
        .channels_credit_release  (release_o),
        .channels_outstanding_full(full_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt(input int c);
        return 32'(dut.r_outstanding[c*4 +: 4]);
    endfunction

    task automatic add_entry(input int idx, input logic [1:0] ch, input logic rd, input bit exp_issue);
        issue_t e;
        iq_valid[idx]       = 1'b1;
        credit_allow[idx]   = 1'b1;
        is_read[idx]        = rd;
        ch_ids[2*idx +: 2]  = ch;
        if (exp_issue) begin
            e = '{ptr: PW'(idx), ch: ch, rd: rd};
            sb.push_back(e);
        end
    endtask

    // One clock: score any ack seen before the edge, then clear that IQ slot as the IQ would.
    task automatic tick();
        logic          ack;
        logic [PW-1:0] p;
        issue_t        e;
        @(negedge clk);
        ack = u_if.iq_issue_ack;
        p   = u_if.iq_issue_ack_ptr;
        if (ack) begin
            if (sb.size() == 0) begin
                check("unexpected_issue_ptr", 32'(p), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("sb_ptr", 32'(p), 32'(e.ptr));
                check("sb_ch", 32'(u_if.issue_ch_id), 32'(e.ch));
                check("sb_rd", 32'(u_if.issue_is_read), 32'(e.rd));
            end
        end
        @(posedge clk);
        #1;
        if (ack) iq_valid[p] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        iq_valid         = '0;
        credit_allow     = '0;
        is_read          = '0;
        ch_ids           = '0;
        bottom           = '0;
        rd_resp_valid    = 1'b0;
        rd_resp_ch       = '0;
        u_if.issue_ready = 1'b0;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(u_if.issue_valid), 32'd0);
        check("rst_ptr", 32'(u_if.issue_ptr), 32'd0);
        check("rst_release", 32'(release_o), 32'd0);
        check("rst_full", 32'(full_o), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Oldest-first from bottom pointer 7: 9 then 5
        u_if.issue_ready = 1'b1;
        bottom = 8'd7;
        add_entry(9, 2'd3, 1'b0, 1'b1);
        add_entry(5, 2'd1, 1'b0, 1'b1);
        #1 check("t1_latency_valid", 32'(u_if.issue_valid), 32'd0);
        tick();
        check("t1_ptr9", 32'(u_if.issue_ptr), 32'd9);
        check("t1_ack9", 32'(u_if.iq_issue_ack), 32'd1);
        check("t1_ackptr9", 32'(u_if.iq_issue_ack_ptr), 32'd9);
        tick();
        check("t1_ptr5", 32'(u_if.issue_ptr), 32'd5);
        check("t1_ackptr5", 32'(u_if.iq_issue_ack_ptr), 32'd5);
        tick();
        check("t1_drain_valid", 32'(u_if.issue_valid), 32'd0);

        // Wrap-around from bottom pointer 255
        bottom = 8'd255;
        add_entry(255, 2'd2, 1'b0, 1'b1);
        add_entry(0, 2'd0, 1'b0, 1'b1);
        tick();
        check("t2_ptr255", 32'(u_if.issue_ptr), 32'd255);
        tick();
        check("t2_ptr0", 32'(u_if.issue_ptr), 32'd0);
        tick();
        check("t2_drain_valid", 32'(u_if.issue_valid), 32'd0);

        // Backpressure: hold entry 3 for 4 cycles, then a single ack
        u_if.issue_ready = 1'b0;
        bottom = 8'd0;
        add_entry(3, 2'd1, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t3_hold_valid", 32'(u_if.issue_valid), 32'd1);
            check("t3_hold_ptr", 32'(u_if.issue_ptr), 32'd3);
            check("t3_hold_ack", 32'(u_if.iq_issue_ack), 32'd0);
            tick();
        end
        u_if.issue_ready = 1'b1;
        #1;
        check("t3_ack", 32'(u_if.iq_issue_ack), 32'd1);
        check("t3_ackptr", 32'(u_if.iq_issue_ack_ptr), 32'd3);
        tick();
        check("t3_no_dup", 32'(u_if.issue_valid), 32'd0);
        tick();
        check("t3_no_dup2", 32'(u_if.issue_valid), 32'd0);

        // Channel 1: 8 reads to full, then 8 responses releasing one credit each
        bottom = 8'd10;
        for (int i = 10; i < 18; i++) add_entry(i, 2'd1, 1'b1, 1'b1);
        repeat (9) tick();
        check("t4_full", 32'(full_o), 32'b010);
        check("t4_cnt8", cnt(1), 32'd8);
        check("t4_no_release", 32'(release_o), 32'd0);
        rd_resp_valid = 1'b1;
        rd_resp_ch    = 2'd1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t4_release", 32'(release_o), 32'b010);
            check("t4_cnt_dec", cnt(1), 32'(7 - i));
        end
        rd_resp_valid = 1'b0;
        check("t4_not_full", 32'(full_o), 32'd0);
        tick();
        check("t4_release_end", 32'(release_o), 32'd0);

        // Channel 2: simultaneous read ack and response at count 3
        bottom = 8'd20;
        for (int i = 20; i < 24; i++) add_entry(i, 2'd2, 1'b1, 1'b1);
        repeat (4) tick();
        check("t5_cnt3", cnt(2), 32'd3);
        check("t5_ack_pending", 32'(u_if.iq_issue_ack), 32'd1);
        check("t5_ackptr23", 32'(u_if.iq_issue_ack_ptr), 32'd23);
        rd_resp_valid = 1'b1;
        rd_resp_ch    = 2'd2;
        tick();
        rd_resp_valid = 1'b0;
        check("t5_cnt_same", cnt(2), 32'd3);
        check("t5_release2", 32'(release_o), 32'b100);
        tick();
        check("t5_release_end", 32'(release_o), 32'd0);

        // Asynchronous reset while FULL with channel 2 count 5
        bottom = 8'd24;
        add_entry(24, 2'd2, 1'b1, 1'b1);
        add_entry(25, 2'd2, 1'b1, 1'b1);
        repeat (3) tick();
        check("t6_cnt5", cnt(2), 32'd5);
        u_if.issue_ready = 1'b0;
        add_entry(26, 2'd2, 1'b1, 1'b1);
        tick();
        check("t6_full_stage", 32'(u_if.issue_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(u_if.issue_valid), 32'd0);
        check("t6_rst_ptr", 32'(u_if.issue_ptr), 32'd0);
        check("t6_rst_ch", 32'(u_if.issue_ch_id), 32'd0);
        check("t6_rst_rd", 32'(u_if.issue_is_read), 32'd0);
        check("t6_rst_cnt", cnt(2), 32'd0);
        check("t6_rst_full", 32'(full_o), 32'd0);
        check("t6_rst_release", 32'(release_o), 32'd0);
        void'(sb.pop_back());
        iq_valid         = '0;
        credit_allow     = '0;
        u_if.issue_ready = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("t6_post_release", 32'(release_o), 32'd0);
        check("t6_post_valid", 32'(u_if.issue_valid), 32'd0);
        tick();
        check("t6_post_release2", 32'(release_o), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bank_isu_issue_select.md
Name: bank_isu_issue_select

Overview:
- Issue stage directly downstream of the bank issue-queue credit manager.
- Each cycle, picks the oldest IQ entry that is both valid and credit-allowed. The search runs circularly from the IQ bottom pointer.
- Holds the picked entry in a registered output stage with a valid/ready handshake to the channel request path, and acknowledges the issued slot back to the IQ.
- Counts outstanding reads per channel. On each read response it produces the per-channel credit-release pulses that feed the credit manager.

Parameters:
CHANNEL_NUM, 3, number of memory channels (ch_id is 2 bits, so at most 4).
PTR_WIDTH, 8, IQ pointer width.
DEPTH, 1<<PTR_WIDTH, IQ entries.
MAX_OUTSTANDING, 8, per-channel read limit; equals the credit manager's credit reset value.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
iq_valid_array  in  DEPTH  IQ entry valid.
credit_allow_array  in  DEPTH  entry holds a credit (from credit manager).
iq_bottom_ptr  in  PTR_WIDTH  oldest IQ entry.
iq_op_is_read_array  in  DEPTH  entry is a read.
ch_id_array  in  2*DEPTH  packed channel ids; entry i is bits [2i+1:2i].
issue_valid  out  1  registered request valid.
issue_ptr  out  PTR_WIDTH  IQ slot of request.
issue_ch_id  out  2  channel of request.
issue_is_read  out  1  request is a read.
issue_ready  in  1  downstream accepts.
iq_issue_ack  out  1  combinational: issue_valid & issue_ready.
iq_issue_ack_ptr  out  PTR_WIDTH  equals issue_ptr; IQ clears this slot's valid on this edge.
rd_resp_valid  in  1  read response returned.
rd_resp_ch_id  in  2  channel of response.
channels_credit_release  out  CHANNEL_NUM  registered one-cycle credit-release pulses.
channels_outstanding_full  out  CHANNEL_NUM  outstanding count == MAX_OUTSTANDING (debug/assert).

Behaviour:
- Eligibility: eligible[i] = iq_valid_array[i] & credit_allow_array[i] & ~(issue_valid & issue_ptr==i).
- Selection:
  - Circular priority starting at iq_bottom_ptr, increasing index with wrap DEPTH-1 -> 0.
  - The first eligible entry wins.
  - sel_found=0 when no entry is eligible.
- Output stage, two states:
  - EMPTY (issue_valid=0): if sel_found, load sel_ptr/ch_id/is_read and go to FULL next cycle. Otherwise stay EMPTY.
  - FULL (issue_valid=1):
    - issue_ready=0: hold all output fields stable, no new load.
    - issue_ready=1 and sel_found: reload in the same cycle and stay FULL. Throughput is 1 issue/cycle.
    - issue_ready=1 and no sel_found: go to EMPTY.
- Latency: an eligible entry appearing at cycle N can present issue_valid at N+1 at the earliest.
- The entry currently held is excluded from selection. The IQ clears its valid on the ack edge, so it is never issued twice.
- Outstanding counters:
  - One per channel, width clog2(MAX_OUTSTANDING)+1.
  - Increment on iq_issue_ack & issue_is_read & issue_ch_id==c.
  - Decrement on rd_resp_valid & rd_resp_ch_id==c.
  - Simultaneous increment and decrement on the same channel leaves the count unchanged.
- Credit release: channels_credit_release[c] is registered and equals the decrement condition delayed one cycle. A response always releases exactly one credit, including on a simultaneous-issue cycle.
- Error conditions (no wrap, simulation assertion fires):
  - Response on a channel whose count is 0: counter holds at 0 and no release pulse is produced.
  - Increment when the count is at MAX_OUTSTANDING: counter saturates.
- Writes (issue_is_read=0) never touch the counters.
- ch_id values >= CHANNEL_NUM are ignored by counters and release.
- Reset (asynchronous, rst_n low), including mid-handshake:
  - Outputs: issue_valid=0, issue_ptr=0, issue_ch_id=0, issue_is_read=0, channels_credit_release=0, channels_outstanding_full=0.
  - Internal state: all counters 0, state EMPTY.
  - A pending request is dropped. Upstream resets together with this block.

Test Plan:
- Reset, then entries 5 and 9 valid and credit-allowed, bottom_ptr=7, ready=1 -> issue_ptr=9 at the next cycle, then 5 one cycle later. Each issue gives a one-cycle iq_issue_ack with a matching ack_ptr.
- Entry 255 and entry 0 eligible, bottom_ptr=255 -> 255 issued first, then 0 (wrap-around).
- Entry 3 eligible, issue_ready=0 for 4 cycles -> issue_valid=1 and issue_ptr=3 stable, iq_issue_ack=0, entry 3 never duplicated. Ready goes high -> single ack.
- Channel 1: issue 8 reads, no responses -> channels_outstanding_full[1]=1. Then send 8 rd_resp_valid with ch_id=1 -> 8 release pulses on bit 1, each one cycle after its response; count returns to 0.
- Same cycle: ack a read to channel 2 and rd_resp on channel 2 with count=3 -> count stays 3, channels_credit_release[2]=1 next cycle.
- Assert rst_n low while FULL with count=5 -> issue_valid=0 and count=0 immediately (asynchronous); no release pulse after reset deasserts.
